// File: rtl/gfx_scanout_pkg.sv
// Package: gfx_scanout_pkg
// Shared geometry, types and constants for the scanline store / palette stage.
//  LINE_W    logical pixels per scanline (display width is 2*LINE_W hpos clocks)
//  PIX_BITS  palette index width, RGB_BITS packed {R,G,B} palette entry width
//  BG_INDEX  index written back by clear-on-read so undrawn lines show entry 0
package gfx_scanout_pkg;

  localparam int LINE_W    = 320;
  localparam int PIX_BITS  = 4;
  localparam int RGB_BITS  = 12;
  localparam int DISP_W    = 2 * LINE_W;
  localparam int X_BITS    = 9;
  localparam int HPOS_BITS = 10;
  localparam int PAL_DEPTH = 1 << PIX_BITS;

  localparam logic [X_BITS-1:0]    LINE_W_X  = 9'd320;
  localparam logic [HPOS_BITS-1:0] DISP_W_H  = 10'd640;
  localparam logic [PIX_BITS-1:0]  BG_INDEX  = 4'd0;

  typedef logic [PIX_BITS-1:0] pix_idx_t;
  typedef logic [RGB_BITS-1:0] rgb_t;

  // Sync/blank bundle carried through the output alignment delay.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

endpackage

// File: rtl/gfx_scanout_if.sv
// Interface: gfx_scanout_if
// Bundles the gfx pixel-write bus, palette-write bus, incoming vga timing and
// the aligned pixel/sync outputs of gfx_scanout.
//  master : the surrounding system (gfx + vga_video + pins)
//  slave  : gfx_scanout
interface gfx_scanout_if;
  import gfx_scanout_pkg::*;

  logic                  scanline_begin_i;
  logic                  pix_we_i;
  logic [X_BITS-1:0]     pix_addr_i;
  pix_idx_t              pix_data_i;
  logic                  pal_we_i;
  pix_idx_t              pal_addr_i;
  rgb_t                  pal_data_i;
  logic [HPOS_BITS-1:0]  video_hpos_i;
  logic                  video_blank_i;
  logic                  video_hsync_i;
  logic                  video_vsync_i;
  rgb_t                  rgb_o;
  logic                  hsync_o;
  logic                  vsync_o;
  logic                  blank_o;

  modport master (
    output scanline_begin_i, pix_we_i, pix_addr_i, pix_data_i,
    output pal_we_i, pal_addr_i, pal_data_i,
    output video_hpos_i, video_blank_i, video_hsync_i, video_vsync_i,
    input  rgb_o, hsync_o, vsync_o, blank_o
  );

  modport slave (
    input  scanline_begin_i, pix_we_i, pix_addr_i, pix_data_i,
    input  pal_we_i, pal_addr_i, pal_data_i,
    input  video_hpos_i, video_blank_i, video_hsync_i, video_vsync_i,
    output rgb_o, hsync_o, vsync_o, blank_o
  );

endinterface

// File: rtl/gfx_scanout_line_ram.sv
// Module: gfx_scanout_line_ram
// One bank of the scanline store: simple dual-port RAM, one write port and one
// synchronous read port (read-before-write on an address collision). Contents
// are not reset.
//  clk    in  clock
//  we     in  write strobe
//  waddr  in  write pixel x
//  wdata  in  palette index to store
//  raddr  in  read pixel x
//  rdata  out registered read data
module gfx_scanout_line_ram #(
  parameter int DEPTH = 320,
  parameter int AW    = 9,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/gfx_scanout.sv
// Module: gfx_scanout
// Double-buffered scanline store, palette lookup and pixel output. gfx fills
// the write bank with the next line while the display bank is read at vga
// hpos (2x horizontal doubling), looked up in a writable palette and driven
// out with sync/blank aligned to it (2-clock latency hpos -> rgb_o).
//  clk, rst  clock, asynchronous active-high reset
//  bus       gfx_scanout_if.slave: pixel/palette write buses, vga timing in,
//            rgb_o/hsync_o/vsync_o/blank_o out
module gfx_scanout
  import gfx_scanout_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  gfx_scanout_if.slave   bus
);

  logic              wr_bank_r;
  logic              in_range_s;
  logic              rd_bank_s;
  logic [X_BITS-1:0] rd_x_s;
  logic              pix_ok_s;

  logic              in_range_d1_r;
  logic              odd_d1_r;
  logic [X_BITS-1:0] x_d1_r;
  logic              bank_d1_r;
  sync_t             sync_d1_r;

  pix_idx_t          rdata_s [2];
  pix_idx_t          idx_s;
  logic              clr_s;

  rgb_t              pal_r [PAL_DEPTH];
  rgb_t              rgb_r;
  sync_t             sync_d2_r;

  // Bank select: flip on every scanline start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r <= 1'b0;
    end else if (bus.scanline_begin_i) begin
      wr_bank_r <= ~wr_bank_r;
    end else begin
      wr_bank_r <= wr_bank_r;
    end
  end

  // S0 decode: visibility, read address and gfx write qualification.
  always_comb begin
    in_range_s = !bus.video_blank_i && (bus.video_hpos_i < DISP_W_H);
    rd_bank_s  = ~wr_bank_r;
    pix_ok_s   = bus.pix_we_i && (bus.pix_addr_i < LINE_W_X);
    if (in_range_s) begin
      rd_x_s = bus.video_hpos_i[HPOS_BITS-1:1];
    end else begin
      rd_x_s = {X_BITS{1'b0}};
    end
  end

  // S0 -> S1 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_range_d1_r <= 1'b0;
      odd_d1_r      <= 1'b0;
      x_d1_r        <= {X_BITS{1'b0}};
      bank_d1_r     <= 1'b0;
      sync_d1_r     <= SYNC_IDLE;
    end else begin
      in_range_d1_r <= in_range_s;
      odd_d1_r      <= bus.video_hpos_i[0];
      x_d1_r        <= rd_x_s;
      bank_d1_r     <= rd_bank_s;
      sync_d1_r     <= {bus.video_hsync_i, bus.video_vsync_i, bus.video_blank_i};
    end
  end

  // S1: pick the bank that was read and decide on clear-on-read, which fires
  // on the second pixel of each doubled pair.
  always_comb begin
    if (bank_d1_r) begin
      idx_s = rdata_s[1];
    end else begin
      idx_s = rdata_s[0];
    end
    clr_s = in_range_d1_r && odd_d1_r;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK_ID = (b == 1);
    logic              we_s;
    logic [X_BITS-1:0] waddr_s;
    pix_idx_t          wdata_s;

    // Per-bank write arbitration: gfx owns the write bank, clear-on-read the
    // bank just displayed. They only collide in a swap cycle while in range;
    // the new line's gfx data then wins.
    always_comb begin
      if (pix_ok_s && (wr_bank_r == BANK_ID)) begin
        we_s    = 1'b1;
        waddr_s = bus.pix_addr_i;
        wdata_s = bus.pix_data_i;
      end else if (clr_s && (bank_d1_r == BANK_ID)) begin
        we_s    = 1'b1;
        waddr_s = x_d1_r;
        wdata_s = BG_INDEX;
      end else begin
        we_s    = 1'b0;
        waddr_s = {X_BITS{1'b0}};
        wdata_s = BG_INDEX;
      end
    end

    gfx_scanout_line_ram #(
      .DEPTH (LINE_W),
      .AW    (X_BITS),
      .DW    (PIX_BITS)
    ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .raddr (rd_x_s),
      .rdata (rdata_s[b])
    );
  end

  // Palette storage; the S2 register below samples the pre-write value.
  always_ff @(posedge clk) begin
    if (bus.pal_we_i) begin
      pal_r[bus.pal_addr_i] <= bus.pal_data_i;
    end
  end

  // S2 output register: colour forced to 0 outside the visible area.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_r     <= {RGB_BITS{1'b0}};
      sync_d2_r <= SYNC_IDLE;
    end else begin
      rgb_r     <= in_range_d1_r ? pal_r[idx_s] : {RGB_BITS{1'b0}};
      sync_d2_r <= sync_d1_r;
    end
  end

  assign bus.rgb_o   = rgb_r;
  assign bus.hsync_o = sync_d2_r.hsync;
  assign bus.vsync_o = sync_d2_r.vsync;
  assign bus.blank_o = sync_d2_r.blank;

endmodule

// File: tb/tb_gfx_scanout.sv
// Testbench: tb_gfx_scanout
// Drives gfx_scanout one clock at a time; each cycle a behavioural model of
// the line banks and palette predicts the output for that cycle's inputs and
// pushes it to a queue, which is popped and compared when it emerges from the
// 2-clock pipeline.
module tb_gfx_scanout;
  import gfx_scanout_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gfx_scanout_if bus ();

  gfx_scanout dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state.
  logic [3:0]  m_ram [2][LINE_W];
  logic [11:0] m_pal [16];
  logic        m_wr;
  logic        pend_clr;
  logic        pend_bank;
  int          pend_x;

  // Stimulus for the next cycle.
  int          s_hpos;
  logic        s_blank, s_hs, s_vs, s_sl, s_pwe, s_lwe;
  int          s_paddr;
  logic [3:0]  s_pdata;
  logic [3:0]  s_laddr;
  logic [11:0] s_ldata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('{rgb: 12'h000, hs: 1'b1, vs: 1'b1, bl: 1'b1});
    m_wr     = 1'b0;
    pend_clr = 1'b0;
  endtask

  // One clock: drive, predict, clock, compare the entry leaving the pipeline.
  task automatic step();
    exp_t        e;
    logic [3:0]  idx;
    logic        in_r;
    logic        rd_bank;
    int          x;
    bus.video_hpos_i     = 10'(s_hpos);
    bus.video_blank_i    = s_blank;
    bus.video_hsync_i    = s_hs;
    bus.video_vsync_i    = s_vs;
    bus.scanline_begin_i = s_sl;
    bus.pix_we_i         = s_pwe;
    bus.pix_addr_i       = 9'(s_paddr);
    bus.pix_data_i       = s_pdata;
    bus.pal_we_i         = s_lwe;
    bus.pal_addr_i       = s_laddr;
    bus.pal_data_i       = s_ldata;

    rd_bank = ~m_wr;
    in_r    = !s_blank && (s_hpos < 640);
    x       = s_hpos / 2;
    idx     = 4'd0;
    if (in_r) idx = m_ram[rd_bank][x];
    if (pend_clr) m_ram[pend_bank][pend_x] = 4'd0;
    if (s_pwe && s_paddr < LINE_W) m_ram[m_wr][s_paddr] = s_pdata;
    pend_clr  = in_r && s_hpos[0];
    pend_bank = rd_bank;
    pend_x    = x;
    if (s_lwe) m_pal[s_laddr] = s_ldata;
    if (s_sl) m_wr = ~m_wr;
    e.rgb = in_r ? m_pal[idx] : 12'h000;
    e.hs  = s_hs;
    e.vs  = s_vs;
    e.bl  = s_blank;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val($sformatf("rgb h=%0d", s_hpos), 32'(bus.rgb_o), 32'(e.rgb));
    check_val("hsync", 32'(bus.hsync_o), 32'(e.hs));
    check_val("vsync", 32'(bus.vsync_o), 32'(e.vs));
    check_val("blank", 32'(bus.blank_o), 32'(e.bl));
    s_sl  = 1'b0;
    s_pwe = 1'b0;
    s_lwe = 1'b0;
  endtask

  task automatic pal_wr(input int a, input logic [11:0] d);
    s_lwe = 1'b1; s_laddr = 4'(a); s_ldata = d;
    step();
  endtask

  task automatic pix_wr(input int xa, input logic [3:0] d);
    s_pwe = 1'b1; s_paddr = xa; s_pdata = d;
    step();
  endtask

  task automatic swap();
    s_sl = 1'b1;
    step();
  endtask

  task automatic sweep(input int h0, input int n);
    for (int i = 0; i < n; i++) begin
      s_hpos = h0 + i; s_blank = 1'b0;
      step();
    end
    s_hpos = 0; s_blank = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " rgb"},   32'(bus.rgb_o),   32'h000);
    check_val({tag, " hsync"}, 32'(bus.hsync_o), 32'h1);
    check_val({tag, " vsync"}, 32'(bus.vsync_o), 32'h1);
    check_val({tag, " blank"}, 32'(bus.blank_o), 32'h1);
  endtask

  initial begin
    s_hpos = 0; s_blank = 1'b1; s_hs = 1'b1; s_vs = 1'b1;
    s_sl = 1'b0; s_pwe = 1'b0; s_lwe = 1'b0;
    s_paddr = 0; s_pdata = 4'd0; s_laddr = 4'd0; s_ldata = 12'h000;
    bus.video_hpos_i = 10'd0; bus.video_blank_i = 1'b1;
    bus.video_hsync_i = 1'b1; bus.video_vsync_i = 1'b1;
    bus.scanline_begin_i = 1'b0; bus.pix_we_i = 1'b0;
    bus.pix_addr_i = 9'd0; bus.pix_data_i = 4'd0;
    bus.pal_we_i = 1'b0; bus.pal_addr_i = 4'd0; bus.pal_data_i = 12'h000;

    // Reset held: outputs at reset values.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Load every palette entry with a distinct colour; entry 5 is red.
    for (int i = 0; i < 16; i++) begin
      pal_wr(i, (i == 5) ? 12'hF00 : (12'h0A5 + 12'(i) * 12'h101));
    end

    // Line of idx5 at x=0..3 in bank 0, then display it.
    for (int i = 0; i < 4; i++) pix_wr(i, 4'd5);
    swap();
    sweep(0, 8);

    // Two swaps without redraw: bank 0 again shows the cleared pixels.
    swap();
    swap();
    sweep(0, 8);

    // Write coincident with swap lands in the pre-swap bank (bank 1).
    s_sl = 1'b1; s_pwe = 1'b1; s_paddr = 10; s_pdata = 4'd3;
    step();
    sweep(20, 2);

    // Right edge of the visible area, beyond it, and blanked.
    pix_wr(319, 4'd7);
    swap();
    sweep(638, 8);
    sweep(700, 1);
    sweep(799, 1);
    s_hpos = 0; s_blank = 1'b1;
    step();

    // Sync pulses must come out exactly two clocks late.
    for (int i = 0; i < 10; i++) begin
      s_hpos = 650 + i; s_blank = 1'b1;
      s_hs = !(i >= 2 && i < 5);
      s_vs = !(i >= 4 && i < 8);
      step();
    end
    s_hs = 1'b1; s_vs = 1'b1;

    // Palette rewrite of entry 5 while it is on screen.
    for (int i = 0; i < 4; i++) pix_wr(i, 4'd5);
    swap();
    for (int i = 0; i < 8; i++) begin
      s_hpos = i; s_blank = 1'b0;
      if (i == 3) begin
        s_lwe = 1'b1; s_laddr = 4'd5; s_ldata = 12'h0F0;
      end
      step();
    end
    s_hpos = 0; s_blank = 1'b1;

    // Out-of-range pixel address must not alias onto x=0.
    pix_wr(0, 4'd2);
    pix_wr(320, 4'd9);
    swap();
    sweep(0, 2);

    // Mid-line reset: outputs forced at once, banks restart at wr_bank=0.
    pix_wr(5, 4'd9);
    s_hpos = 2; s_blank = 1'b0;
    step();
    s_hpos = 3;
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-line reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    s_hpos = 0; s_blank = 1'b1;
    step();
    sweep(10, 2);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
